seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan.sv | 139 +++++++++++++
 tb/tb_seg7_scan.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed 7-segment display driver for DIGITS digits, with hex or raw
// segment decoding. Define SEG7_SCAN_DIM_EN to add a brightness input with 16-step PWM dimming.

module seg7_scan #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              raw_mode,
`ifdef SEG7_SCAN_DIM_EN
  input  logic [3:0]        brightness,
`endif
  output logic              wr_ack,
  output logic [0:6]        seg,
  output logic              dp,
  output logic [0:DIGITS-1] an
);

  localparam int             PW        = $clog2(DIV);
  localparam int             IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(DIV - 1);
  localparam logic [IW-1:0]  IDX_MAX   = IW'(DIGITS - 1);
  localparam logic [3:0]     DIG_LIM   = 4'(DIGITS);

  // Write port has no backpressure: a write is taken on any clk edge with wr_en=1 and
  // wr_addr<DIGITS, and wr_ack is high for exactly the one cycle that follows it.

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              run_q, run_d;
  logic [7:0]        digit_q [DIGITS];
  logic [7:0]        digit_d [DIGITS];
  logic              wr_ack_q, wr_ack_d;
  logic [0:6]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [0:DIGITS-1] an_q, an_d;
  logic              tick, wr_hit, lit;
  logic [7:0]        cur;
`ifdef SEG7_SCAN_DIM_EN
  logic [3:0]        pwm_q, pwm_d;
`endif

  function automatic logic [0:6] hex_seg(input logic [3:0] v);
    logic [0:6] s;
    s = '1;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      4'hF: s = 7'b0111000;
      default: s = '1;
    endcase
    return s;
  endfunction

  always_comb begin
    tick     = (presc_q == PRESC_MAX);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    wr_hit   = wr_en && ({1'b0, wr_addr} < DIG_LIM);
    wr_ack_d = wr_hit;
    digit_d  = digit_q;
    if (wr_hit) digit_d[wr_addr[IW-1:0]] = wr_data;

    // The first tick after reset opens digit 0's slot; later ticks advance the index.
    run_d = run_q | tick;
    idx_d = idx_q;
    if (tick && run_q) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;

    cur = digit_q[idx_q];
    if (raw_mode) begin
      seg_d = ~cur[6:0];
      dp_d  = ~cur[7];
    end else if (cur[4]) begin
      seg_d = '1;
      dp_d  = 1'b1;
    end else begin
      seg_d = hex_seg(cur[3:0]);
      dp_d  = ~cur[7];
    end

    // Anodes stay dark before the scan starts and for the guard cycle after every tick.
    lit = run_q && !tick;
`ifdef SEG7_SCAN_DIM_EN
    lit   = lit && (pwm_q < brightness);
    pwm_d = pwm_q + 4'd1;
`endif
    for (int i = 0; i < DIGITS; i++) an_d[i] = !(lit && (idx_q == IW'(i)));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q  <= '0;
      idx_q    <= '0;
      run_q    <= 1'b0;
      digit_q  <= '{default: 8'h10};
      wr_ack_q <= 1'b0;
      seg_q    <= '1;
      dp_q     <= 1'b1;
      an_q     <= '1;
`ifdef SEG7_SCAN_DIM_EN
      pwm_q    <= '0;
`endif
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      run_q    <= run_d;
      digit_q  <= digit_d;
      wr_ack_q <= wr_ack_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
`ifdef SEG7_SCAN_DIM_EN
      pwm_q    <= pwm_d;
`endif
    end
  end

  assign wr_ack = wr_ack_q;
  assign seg    = seg_q;
  assign dp     = dp_q;
  assign an     = an_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Testbench for seg7_scan (DIGITS=4, DIV=4): slot-arithmetic reference model checked every
// cycle, plus directed vectors with literal expectations.

module tb_seg7_scan;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int W      = DIGITS + 9;

  logic              clk      = 1'b0;
  logic              reset_n  = 1'b0;
  logic              wr_en    = 1'b0;
  logic [2:0]        wr_addr  = '0;
  logic [7:0]        wr_data  = '0;
  logic              raw_mode = 1'b0;
`ifdef SEG7_SCAN_DIM_EN
  logic [3:0]        brightness = 4'd15;
`endif
  logic              wr_ack;
  logic [0:6]        seg;
  logic              dp;
  logic [0:DIGITS-1] an;

  always #5 clk = ~clk;

  seg7_scan #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .raw_mode (raw_mode),
`ifdef SEG7_SCAN_DIM_EN
    .brightness (brightness),
`endif
    .wr_ack   (wr_ack),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  localparam logic [6:0] HEX_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Reference model: n counts edges since the last reset edge; slot k (k>=1) starts at edge
  // k*DIV, the first cycle of each slot is dark, and slot k shows digit (k-1) mod DIGITS.
  int                n;
  bit                model_on = 1'b0;
  logic [7:0]        mem [DIGITS];
  logic [7:0]        m_d;
  logic [6:0]        m_s;
  logic              m_p, m_k, m_lit;
  logic [DIGITS-1:0] m_a;
  logic [1:0]        m_i;

  function automatic int slot_of(input int m);
    int t;
    t = m / DIV;
    return (t == 0) ? 0 : (t - 1) % DIGITS;
  endfunction

  function automatic logic [DIGITS-1:0] onehot(input int i);
    logic [DIGITS-1:0] v;
    v = '1;
    v[DIGITS-1-i] = 1'b0;
    return v;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      n = 0;
      for (int i = 0; i < DIGITS; i++) mem[i] = 8'h10;
      model_on = 1'b1;
      exp_q.push_back({{DIGITS{1'b1}}, 7'h7F, 1'b1, 1'b0});
    end else if (model_on) begin
      n   = n + 1;
      m_i = 2'(slot_of(n - 1));
      m_d = mem[m_i];
      if (raw_mode) begin
        m_s = ~m_d[6:0];
        m_p = ~m_d[7];
      end else if (m_d[4]) begin
        m_s = 7'h7F;
        m_p = 1'b1;
      end else begin
        m_s = HEX_TAB[m_d[3:0]];
        m_p = ~m_d[7];
      end
      m_k = wr_en && (int'(wr_addr) < DIGITS);
      if (m_k) mem[wr_addr[1:0]] = wr_data;
      m_lit = ((n / DIV) != 0) && ((n % DIV) != 0);
`ifdef SEG7_SCAN_DIM_EN
      m_lit = m_lit && (((n - 1) % 16) < int'(brightness));
`endif
      m_a = m_lit ? onehot(slot_of(n)) : '1;
      exp_q.push_back({m_a, m_s, m_p, m_k});
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if ({an, seg, dp, wr_ack} !== e) begin
        bad++;
        $display("FAIL cycle n=%0d: got an=%b seg=%b dp=%b ack=%b, expected an=%b seg=%b dp=%b ack=%b",
                 n, an, seg, dp, wr_ack, e[W-1:9], e[8:2], e[1], e[0]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] v);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = v;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic next_entry(output logic [DIGITS-1:0] seen, output bit ok);
    logic [DIGITS-1:0] prev;
    ok   = 1'b0;
    seen = '1;
    for (int i = 0; i < 24; i++) begin
      prev = an;
      @(negedge clk);
      if (prev == '1 && an != '1) begin
        seen = an;
        ok   = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_slot(input int idx);
    logic [DIGITS-1:0] seen;
    bit e_ok, hit;
    hit = 1'b0;
    for (int k = 0; k <= DIGITS; k++) begin
      next_entry(seen, e_ok);
      if (!e_ok) break;
      if (seen == onehot(idx)) begin
        hit = 1'b1;
        break;
      end
    end
    chk($sformatf("wait_slot%0d_found", idx), 32'(hit), 32'd1);
  endtask

  task automatic count_first_anode(input string name);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt++;
      if (an != '1) break;
    end
    chk({name, "_cycles"}, cnt, 5);
    chk({name, "_an"}, 32'(an), 32'b0111);
  endtask

  logic [6:0] scan_seg [5] = '{7'b1001111, 7'b0001000, 7'b0111000, 7'b0000000, 7'b1001111};
  logic       scan_dp  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    logic [DIGITS-1:0] seen;
    bit ok;
    int cnt;

    // Reset held for three cycles
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_an", 32'(an), 32'b1111);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_dp", 32'(dp), 32'd1);
    chk("reset_ack", 32'(wr_ack), 32'd0);
    reset_n = 1'b1;
    count_first_anode("first_anode");
    chk("first_anode_seg_blank", 32'(seg), 32'h7F);

    // Hex writes and scan order 0,1,2,3,0
    do_write(3'd0, 8'h01);
    do_write(3'd1, 8'h0A);
    do_write(3'd2, 8'h8F);
    do_write(3'd3, 8'h08);
    wait_slot(0);
    chk("scan0_seg", 32'(seg), 32'(scan_seg[0]));
    chk("scan0_dp", 32'(dp), 32'(scan_dp[0]));
    for (int k = 1; k < 5; k++) begin
      next_entry(seen, ok);
      chk($sformatf("scan%0d_entry", k), 32'(ok), 32'd1);
      chk($sformatf("scan%0d_an", k), 32'(seen), 32'(onehot(k % DIGITS)));
      chk($sformatf("scan%0d_seg", k), 32'(seg), 32'(scan_seg[k]));
      chk($sformatf("scan%0d_dp", k), 32'(dp), 32'(scan_dp[k]));
    end

    // Out-of-range write is ignored; valid write acks for exactly one cycle
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h00;
    @(negedge clk);
    wr_en = 1'b0;
    chk("oor_no_ack", 32'(wr_ack), 32'd0);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h0A;
    @(negedge clk);
    wr_en = 1'b0;
    chk("valid_ack_high", 32'(wr_ack), 32'd1);
    @(negedge clk);
    chk("valid_ack_low", 32'(wr_ack), 32'd0);
    wait_slot(0);
    chk("oor_digit0_kept", 32'(seg), 32'b1001111);

    // Raw mode
    raw_mode = 1'b1;
    do_write(3'd0, 8'h7F);
    wait_slot(0);
    chk("raw_7f_seg", 32'(seg), 32'h00);
    chk("raw_7f_dp", 32'(dp), 32'd1);
    do_write(3'd0, 8'h80);
    wait_slot(0);
    chk("raw_80_seg", 32'(seg), 32'h7F);
    chk("raw_80_dp", 32'(dp), 32'd0);
    raw_mode = 1'b0;
    @(negedge clk);
    chk("raw_off_seg", 32'(seg), 32'b0000001);

    // Write latency to the scanned digit
    wait_slot(0);
    do_write(3'd0, 8'h03);
    chk("lat_1cyc_old", 32'(seg), 32'b0000001);
    @(negedge clk);
    chk("lat_2cyc_new", 32'(seg), 32'b0000110);
    chk("lat_2cyc_dp", 32'(dp), 32'd1);

    // Write coinciding with a tick is used for the new digit
    wait_slot(0);
    repeat (2) @(negedge clk);
    do_write(3'd1, 8'h05);
    chk("tickwr_guard_an", 32'(an), 32'b1111);
    @(negedge clk);
    chk("tickwr_an", 32'(an), 32'b1011);
    chk("tickwr_seg", 32'(seg), 32'b0100100);

    // Mid-scan reset wins over a simultaneous write
    reset_n = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h08;
    @(negedge clk);
    wr_en = 1'b0;
    chk("midrst_an", 32'(an), 32'b1111);
    chk("midrst_seg", 32'(seg), 32'h7F);
    chk("midrst_ack", 32'(wr_ack), 32'd0);
    reset_n = 1'b1;
    count_first_anode("midrst_first");
    chk("midrst_write_ignored", 32'(seg), 32'h7F);

`ifdef SEG7_SCAN_DIM_EN
    brightness = 4'd0;
    repeat (2) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an != '1) cnt++;
    end
    chk("dim_dark", cnt, 0);
    brightness = 4'd4;
    repeat (64) @(negedge clk);
`else
    cnt = 0;
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
